// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and width helpers for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } requester_e;

    localparam int c_MIN_CNT_W = 1;

    // Bits needed to hold every value 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < c_MIN_CNT_W) ? c_MIN_CNT_W : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Saturating count of consecutive fetch losses; at_limit makes
//               fetch win the next contested arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int WIDTH = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Clear dominates increment so a fetch grant always restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign at_limit = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               data access, with fixed-latency read tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = XLEN / 2,
    parameter int MEM_LATENCY        = 2,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          if_req,
    input  logic [XLEN-1:0]               if_addr,
    output logic                          if_gnt,
    output logic                          if_rvalid,
    output logic [INSTRUCTION_LENGTH-1:0] if_rdata,

    input  logic                          dm_req,
    input  logic                          dm_we,
    input  logic [XLEN-1:0]               dm_addr,
    input  logic [XLEN-1:0]               dm_wdata,
    output logic                          dm_gnt,
    output logic                          dm_rvalid,
    output logic [XLEN-1:0]               dm_rdata,

    output logic                          mem_en,
    output logic                          mem_we,
    output logic [XLEN-1:0]               mem_addr,
    output logic [XLEN-1:0]               mem_wdata,
    input  logic [XLEN-1:0]               mem_rdata,

    output logic                          busy
);

    localparam int                  c_WAIT_W = cnt_width(MEM_LATENCY);
    localparam logic [c_WAIT_W-1:0] c_LAT    = c_WAIT_W'(MEM_LATENCY);
    localparam logic [c_WAIT_W-1:0] c_LAST   = c_WAIT_W'(1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    requester_e          r_owner;
    requester_e          w_owner_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;

    logic w_idle;
    logic w_if_win;
    logic w_dm_win;
    logic w_rd_grant;
    logic w_at_limit;
    logic w_starve_inc;
    logic w_starve_clr;
    logic w_rvalid_slot;

    assign w_idle = (r_state == IDLE);

    // ------------------------------------------------------------------------
    // Arbitration: data beats fetch unless fetch has lost too many times.
    // Reset low suppresses every grant in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_if_win = 1'b0;
        w_dm_win = 1'b0;
        if (rst && w_idle) begin
            if (if_req && (!dm_req || w_at_limit)) begin
                w_if_win = 1'b1;
            end else if (dm_req) begin
                w_dm_win = 1'b1;
            end
        end
    end

    assign w_rd_grant = w_if_win || (w_dm_win && !dm_we);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_rd_grant) begin
                    w_state_nxt    = WAIT;
                    w_owner_nxt    = w_if_win ? REQ_IF : REQ_DM;
                    w_wait_cnt_nxt = c_LAT;
                end
            end
            WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - c_LAST;
                if (r_wait_cnt == c_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= REQ_IF;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Starvation guard: only contested IDLE cycles that fetch loses count;
    // the counter freezes while a read is outstanding.
    // ------------------------------------------------------------------------
    assign w_starve_inc = w_idle && if_req && dm_req && w_dm_win;
    assign w_starve_clr = w_if_win || (w_idle && !if_req);

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_starve_inc),
        .clr      (w_starve_clr),
        .at_limit (w_at_limit)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign if_gnt = w_if_win;
    assign dm_gnt = w_dm_win;
    assign mem_en = w_if_win || w_dm_win;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_win) begin
            mem_addr = if_addr;
        end else if (w_dm_win) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    assign busy          = rst && !w_idle;
    assign w_rvalid_slot = busy && (r_wait_cnt == c_LAST);
    assign if_rvalid     = w_rvalid_slot && (r_owner == REQ_IF);
    assign dm_rvalid     = w_rvalid_slot && (r_owner == REQ_DM);

    assign if_rdata = mem_rdata[INSTRUCTION_LENGTH-1:0];
    assign dm_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scenarios plus a randomized run against a
//               cycle-timestamp reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int XLEN  = 64;
    localparam int IL    = 32;
    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    // control vector bit positions: {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}
    localparam logic [6:0] c_IFG = 7'b1000000;
    localparam logic [6:0] c_DMG = 7'b0100000;
    localparam logic [6:0] c_IFV = 7'b0010000;
    localparam logic [6:0] c_DMV = 7'b0001000;
    localparam logic [6:0] c_EN  = 7'b0000100;
    localparam logic [6:0] c_WE  = 7'b0000010;
    localparam logic [6:0] c_BSY = 7'b0000001;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [IL-1:0]   if_rdata;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            busy;
    logic [6:0]      ctl;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] mem_img [logic [XLEN-1:0]];
    logic [XLEN-1:0] pipe [LAT];

    mem_port_arbiter #(
        .XLEN               (XLEN),
        .INSTRUCTION_LENGTH (IL),
        .MEM_LATENCY        (LAT),
        .STARVE_LIMIT       (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign ctl = {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy};

    function automatic logic [XLEN-1:0] mem_read(input logic [XLEN-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Memory macro emulation: call at the negedge, returns at posedge + 1.
    task automatic advance();
        logic            rd;
        logic            wr;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] d;
        rd = mem_en && !mem_we;
        wr = mem_en && mem_we;
        a  = mem_addr;
        d  = mem_wdata;
        @(posedge clk);
        if (wr) mem_img[a] = d;
        for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i+1];
        pipe[LAT-1] = rd ? mem_read(a) : {$urandom(), $urandom()};
        mem_rdata = pipe[0];
        #1;
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = 64'h40; dm_addr = 64'h80; dm_wdata = 64'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 7'b0) begin
                errors++; $display("FAIL reset_ctl[%0d]: got %b expected %b", k, ctl, 7'b0);
            end
            checks++;
            if ({mem_addr, mem_wdata} !== '0) begin
                errors++; $display("FAIL reset_bus[%0d]: got %h/%h expected 0", k, mem_addr, mem_wdata);
            end
            advance();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== (c_DMG | c_EN)) begin
            errors++; $display("FAIL reset_first_grant: got %b expected %b", ctl, c_DMG | c_EN);
        end
        advance();
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk); advance();
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== mem_read(64'h80)) begin
            errors++; $display("FAIL reset_first_load: got %b/%h expected 1/%h", dm_rvalid, dm_rdata, mem_read(64'h80));
        end
        advance();
        @(negedge clk); advance();
    endtask

    task automatic test_single_fetch();
        mem_img[64'h100] = 64'h0000_0000_DEAD_BEEF;
        if_req = 1'b1; if_addr = 64'h100;
        @(negedge clk);
        checks++;
        if (ctl !== (c_IFG | c_EN) || mem_addr !== 64'h100 || mem_wdata !== '0) begin
            errors++; $display("FAIL fetch_grant: got %b addr %h expected %b addr 100", ctl, mem_addr, c_IFG | c_EN);
        end
        advance();
        if_req = 1'b0; if_addr = 64'h0;
        @(negedge clk);
        checks++;
        if (ctl !== c_BSY) begin
            errors++; $display("FAIL fetch_wait: got %b expected %b", ctl, c_BSY);
        end
        advance();
        @(negedge clk);
        checks++;
        if (ctl !== (c_IFV | c_BSY) || if_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_rvalid: got %b/%h expected %b/deadbeef", ctl, if_rdata, c_IFV | c_BSY);
        end
        advance();
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL fetch_idle: got %b expected 0", ctl);
        end
        advance();
    endtask

    task automatic test_conflict();
        logic [6:0] exp_seq [7];
        exp_seq = '{c_DMG | c_EN, c_BSY, c_DMV | c_BSY, c_IFG | c_EN, c_BSY, c_IFV | c_BSY, 7'b0};
        if_req = 1'b1; if_addr = 64'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (ctl !== exp_seq[k]) begin
                errors++; $display("FAIL conflict_ctl[T+%0d]: got %b expected %b", k, ctl, exp_seq[k]);
            end
            if (k == 2) begin
                checks++;
                if (dm_rdata !== mem_read(64'h200)) begin
                    errors++; $display("FAIL conflict_dm_rdata: got %h expected %h", dm_rdata, mem_read(64'h200));
                end
            end
            if (k == 3) begin
                checks++;
                if (mem_addr !== 64'h300) begin
                    errors++; $display("FAIL conflict_if_addr: got %h expected 300", mem_addr);
                end
            end
            advance();
            if (k == 0) dm_req = 1'b0;
            if (k == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        logic [6:0] exp_ctl;
        if_req = 1'b1; if_addr = 64'h400;
        dm_req = 1'b1; dm_we = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                dm_addr  = 64'h600 + 64'(8 * k);
                dm_wdata = 64'hA000 + 64'(k);
            end
            if (k < 4 || k == 7)  exp_ctl = c_DMG | c_EN | c_WE;
            else if (k == 4)      exp_ctl = c_IFG | c_EN;
            else if (k == 5)      exp_ctl = c_BSY;
            else                  exp_ctl = c_IFV | c_BSY;
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("FAIL starve_ctl[%0d]: got %b expected %b", k, ctl, exp_ctl);
            end
            if (k == 7) begin
                checks++;
                if (mem_addr !== 64'h620 || mem_wdata !== 64'hA004) begin
                    errors++; $display("FAIL starve_resume: got %h/%h expected 620/a004", mem_addr, mem_wdata);
                end
            end
            advance();
            if (k == 4) if_req = 1'b0;
        end
        idle_inputs();
        @(negedge clk); advance();
    endtask

    task automatic test_reset_mid_read();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h500;
        @(negedge clk);
        checks++;
        if (ctl !== (c_DMG | c_EN)) begin
            errors++; $display("FAIL midrst_grant: got %b expected %b", ctl, c_DMG | c_EN);
        end
        advance();
        dm_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0) begin
            errors++; $display("FAIL midrst_reset_cycle: got %b expected 0", ctl);
        end
        advance();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 7'b0) begin
                errors++; $display("FAIL midrst_after[%0d]: got %b expected 0", k, ctl);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] data [3];
        data = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
        dm_req = 1'b1; dm_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dm_addr = 64'(8 * k); dm_wdata = data[k];
            @(negedge clk);
            checks++;
            if (ctl !== (c_DMG | c_EN | c_WE) || mem_addr !== 64'(8 * k) || mem_wdata !== data[k]) begin
                errors++; $display("FAIL b2b_store[%0d]: got %b %h %h expected %b %h %h",
                                   k, ctl, mem_addr, mem_wdata, c_DMG | c_EN | c_WE, 64'(8 * k), data[k]);
            end
            advance();
        end
        dm_we = 1'b0; dm_addr = 64'h8; dm_wdata = '0;
        @(negedge clk); advance();
        dm_req = 1'b0;
        @(negedge clk); advance();
        @(negedge clk);
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== data[1]) begin
            errors++; $display("FAIL b2b_readback: got %b/%h expected 1/%h", dm_rvalid, dm_rdata, data[1]);
        end
        advance();
        idle_inputs();
        @(negedge clk); advance();
    endtask

    // Reference model: grants allowed once the cycle count reaches ready_at;
    // a read granted at cycle c returns at c+LAT and frees the port at c+LAT+1.
    task automatic test_random(input int ncyc);
        int              cyc      = 0;
        int              ready_at = 0;
        int              rv_at    = -1;
        int              starve   = 0;
        bit              rv_dm    = 1'b0;
        logic [XLEN-1:0] rv_data  = '0;
        bit              if_pend  = 1'b0;
        bit              dm_pend  = 1'b0;
        bit              idle;
        bit              eg_if;
        bit              eg_dm;
        bit              eg_rv;
        logic [6:0]      exp_ctl;
        logic [XLEN-1:0] exp_addr;
        logic [XLEN-1:0] exp_wdata;
        for (int n = 0; n < ncyc; n++) begin
            rst = (n == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_addr = 64'($urandom_range(0, 31)) << 3;
            end else if (if_pend && $urandom_range(0, 39) == 0) begin
                if_pend = 1'b0;
            end
            if (!dm_pend && $urandom_range(0, 1) == 0) begin
                dm_pend  = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 64'($urandom_range(0, 31)) << 3;
                dm_wdata = {$urandom(), $urandom()};
            end else if (dm_pend && $urandom_range(0, 39) == 0) begin
                dm_pend = 1'b0;
            end
            if_req = if_pend;
            dm_req = dm_pend;
            @(negedge clk);
            idle  = (cyc >= ready_at);
            eg_if = rst && idle && if_req && (!dm_req || starve == LIMIT);
            eg_dm = rst && idle && dm_req && !eg_if;
            eg_rv = rst && (cyc == rv_at);
            exp_ctl   = {eg_if, eg_dm, eg_rv && !rv_dm, eg_rv && rv_dm,
                         eg_if || eg_dm, eg_dm && dm_we, rst && !idle};
            exp_addr  = eg_if ? if_addr : (eg_dm ? dm_addr : '0);
            exp_wdata = eg_dm ? dm_wdata : '0;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("FAIL rand_ctl[%0d]: got %b expected %b", cyc, ctl, exp_ctl);
            end
            checks++;
            if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                errors++; $display("FAIL rand_bus[%0d]: got %h/%h expected %h/%h", cyc, mem_addr, mem_wdata, exp_addr, exp_wdata);
            end
            if (eg_rv) begin
                checks++;
                if ((rv_dm && dm_rdata !== rv_data) || (!rv_dm && if_rdata !== rv_data[IL-1:0])) begin
                    errors++; $display("FAIL rand_rdata[%0d]: got if %h dm %h expected %h", cyc, if_rdata, dm_rdata, rv_data);
                end
            end
            if (!rst) begin
                ready_at = cyc + 1;
                rv_at    = -1;
                starve   = 0;
            end else begin
                if (eg_if || (eg_dm && !dm_we)) begin
                    rv_at    = cyc + LAT;
                    ready_at = cyc + LAT + 1;
                    rv_dm    = eg_dm;
                    rv_data  = mem_read(eg_if ? if_addr : dm_addr);
                end
                if (idle) begin
                    if (eg_if || !if_req)  starve = 0;
                    else if (dm_req)       starve = (starve < LIMIT) ? starve + 1 : LIMIT;
                end
            end
            if (eg_if) if_pend = 1'b0;
            if (eg_dm) dm_pend = 1'b0;
            advance();
            cyc++;
        end
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); advance();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_reset_mid_read();
        test_back_to_back();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
